li_expander: RTL and testbench

LI_EXPANDER -- requirements
Module: li_expander

---
 rtl/li_expander.sv | 125 ++++++++++++
 tb/tb_li_expander.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/li_expander.sv
// Load-immediate expander: turns a 32-bit constant into one or two MIPS I-type
// instructions (ADDIU / ORI / LUI, or LUI followed by ORI) with a valid/ready handshake on each side.
module li_expander (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rt,
   input  logic [31:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EMIT_A = 2'd1;
   localparam logic [1:0] EMIT_B = 2'd2;

   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   logic [1:0]  state_reg, state_next;
   logic        valid_reg, valid_next;
   logic [31:0] instr_reg, instr_next;
   logic        last_reg, last_next;
   logic [4:0]  rt_reg, rt_next;
   logic [15:0] lo_reg, lo_next;

   logic [15:0] in_hi, in_lo;
   logic        sign_fits;
   logic [31:0] first_word;
   logic        first_last;

   assign in_hi     = in_value[31:16];
   assign in_lo     = in_value[15:0];
   assign sign_fits = (in_value[31:15] == 17'h00000) || (in_value[31:15] == 17'h1FFFF);

   // Priority: sign-extended ADDIU, zero-extended ORI, bare LUI, then LUI+ORI pair.
   always_comb begin
      first_word = {OP_LUI, 5'd0, in_rt, in_hi};
      first_last = 1'b1;
      if (sign_fits) begin
         first_word = {OP_ADDIU, 5'd0, in_rt, in_lo};
      end else if (in_hi == 16'h0000) begin
         first_word = {OP_ORI, 5'd0, in_rt, in_lo};
      end else if (in_lo != 16'h0000) begin
         first_last = 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      valid_next = valid_reg;
      instr_next = instr_reg;
      last_next  = last_reg;
      rt_next    = rt_reg;
      lo_next    = lo_reg;
      if (flush) begin
         state_next = IDLE;
         valid_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  state_next = EMIT_A;
                  valid_next = 1'b1;
                  instr_next = first_word;
                  last_next  = first_last;
                  rt_next    = in_rt;
                  lo_next    = in_lo;
               end
            end
            EMIT_A: begin
               if (out_ready) begin
                  if (last_reg) begin
                     state_next = IDLE;
                     valid_next = 1'b0;
                  end else begin
                     state_next = EMIT_B;
                     instr_next = {OP_ORI, rt_reg, rt_reg, lo_reg};
                     last_next  = 1'b1;
                  end
               end
            end
            EMIT_B: begin
               if (out_ready) begin
                  state_next = IDLE;
                  valid_next = 1'b0;
               end
            end
            default: begin
               state_next = IDLE;
               valid_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         valid_reg <= 1'b0;
         instr_reg <= 32'h0;
         last_reg  <= 1'b0;
         rt_reg    <= 5'd0;
         lo_reg    <= 16'h0;
      end else begin
         state_reg <= state_next;
         valid_reg <= valid_next;
         instr_reg <= instr_next;
         last_reg  <= last_next;
         rt_reg    <= rt_next;
         lo_reg    <= lo_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = valid_reg;
   assign out_instr = instr_reg;
   assign out_last  = last_reg;

endmodule

// File: tb/tb_li_expander.sv
// Directed bench for li_expander: a vector table of constants with hand-encoded
// instruction words, plus sequences for stalls, reset mid-expansion and flush.
module tb_li_expander;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rt;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;

   int compared   = 0;
   int mismatched = 0;
   int delivered  = 0;

   li_expander dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rt     (in_rt),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (out_valid && out_ready) delivered <= delivered + 1;
   end

   typedef struct {
      logic [4:0]  rt;
      logic [31:0] value;
      logic [31:0] w0;
      logic        l0;
      logic        two;
      logic [31:0] w1;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one request and drive the pipeline with out_ready=1, checking every word.
   task automatic run_vec(input vec_t v, input int idx);
      in_valid  = 1'b1;
      in_rt     = v.rt;
      in_value  = v.value;
      out_ready = 1'b1;
      check($sformatf("v%0d in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_rt    = ~v.rt;
      in_value = ~v.value;
      check($sformatf("v%0d valid_a", idx), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d word_a", idx), out_instr, v.w0);
      check($sformatf("v%0d last_a", idx), {31'd0, out_last}, {31'd0, v.l0});
      check($sformatf("v%0d in_ready_busy", idx), {31'd0, in_ready}, 32'd0);
      tick();
      if (v.two) begin
         check($sformatf("v%0d valid_b", idx), {31'd0, out_valid}, 32'd1);
         check($sformatf("v%0d word_b", idx), out_instr, v.w1);
         check($sformatf("v%0d last_b", idx), {31'd0, out_last}, 32'd1);
         tick();
      end
      check($sformatf("v%0d valid_done", idx), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d in_ready_done", idx), {31'd0, in_ready}, 32'd1);
      $display("vec %0d: rt=%0d value=%h -> %h%s", idx, v.rt, v.value, v.w0,
               v.two ? $sformatf(" + %h", v.w1) : "");
   endtask

   initial begin
      int d0;
      vecs[0]  = '{5'd8,  32'h00000005, 32'h24080005, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{5'd8,  32'hFFFF8000, 32'h24088000, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{5'd9,  32'h0000ABCD, 32'h3409ABCD, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{5'd10, 32'h12340000, 32'h3C0A1234, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{5'd10, 32'h12345678, 32'h3C0A1234, 1'b0, 1'b1, 32'h354A5678};
      vecs[5]  = '{5'd0,  32'h00000000, 32'h24000000, 1'b1, 1'b0, 32'h0};
      vecs[6]  = '{5'd3,  32'h00008000, 32'h34038000, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{5'd31, 32'hFFFFFFFF, 32'h241FFFFF, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{5'd5,  32'h00007FFF, 32'h24057FFF, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{5'd5,  32'h00010000, 32'h3C050001, 1'b1, 1'b0, 32'h0};
      vecs[10] = '{5'd0,  32'h80000001, 32'h3C008000, 1'b0, 1'b1, 32'h34000001};
      vecs[11] = '{5'd31, 32'hFFFF7FFF, 32'h3C1FFFFF, 1'b0, 1'b1, 32'h37FF7FFF};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rt = 5'd0;
      in_value = 32'h0; out_ready = 1'b0;
      #1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_instr", out_instr, 32'h0);
      check("rst out_last", {31'd0, out_last}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Stall five cycles in each emit state of a two-word expansion.
      d0 = delivered;
      out_ready = 1'b0; in_valid = 1'b1; in_rt = 5'd10; in_value = 32'h12345678;
      tick();
      in_valid = 1'b0; in_value = 32'h0; in_rt = 5'd0;
      for (int c = 0; c < 5; c++) begin
         check("stall_a word", out_instr, 32'h3C0A1234);
         check("stall_a ctl", {29'd0, out_valid, out_last, in_ready}, {29'd0, 3'b100});
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("stall_b word", out_instr, 32'h354A5678);
         check("stall_b ctl", {29'd0, out_valid, out_last, in_ready}, {29'd0, 3'b110});
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("stall done valid", {31'd0, out_valid}, 32'd0);
      check("stall words", delivered - d0, 32'd2);
      $display("stall: delivered %0d words", delivered - d0);

      // Reset pulsed while the ORI is pending.
      in_valid = 1'b1; in_rt = 5'd10; in_value = 32'h12345678;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("pre-rst in emit_b", out_instr, 32'h354A5678);
      d0 = delivered;
      rst_n = 1'b0;
      #1;
      check("rst async valid", {31'd0, out_valid}, 32'd0);
      check("rst async instr", out_instr, 32'h0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) tick();
      check("post-rst no word", delivered - d0, 32'd0);
      check("post-rst valid", {31'd0, out_valid}, 32'd0);
      $display("reset mid-expansion: out_valid=%b in_ready=%b", out_valid, in_ready);

      // Flush while the LUI is presented.
      out_ready = 1'b0;
      in_valid = 1'b1; in_rt = 5'd10; in_value = 32'h12345678;
      tick();
      in_valid = 1'b0;
      check("flush pre valid", {31'd0, out_valid}, 32'd1);
      d0 = delivered;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      check("flush valid", {31'd0, out_valid}, 32'd0);
      check("flush in_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) tick();
      check("flush no word", delivered - d0, 32'd0);
      $display("flush in EMIT_A: out_valid=%b in_ready=%b", out_valid, in_ready);

      // Flush wins over a request offered in the same cycle.
      flush = 1'b1; in_valid = 1'b1; in_rt = 5'd8; in_value = 32'h5;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush blocks req valid", {31'd0, out_valid}, 32'd0);
      check("flush blocks req ready", {31'd0, in_ready}, 32'd1);
      $display("flush vs request: out_valid=%b", out_valid);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
